// File: rtl/cdc_handshake_src.sv
// Source end of a 4-phase req/ack crossing: holds a word on dest_data, raises dest_req,
// and waits for a synchronized dest_ack to rise and fall before accepting the next word.
module cdc_handshake_src #(
    parameter int unsigned WIDTH        = 32,
    parameter int unsigned DEST_SYNC_FF = 2,
    parameter int unsigned TIMEOUT      = 0
) (
    input  logic             src_clk,
    input  logic             src_rst_n,
    input  logic [WIDTH-1:0] s_data,
    input  logic             s_valid,
    output logic             s_ready,
    output logic [WIDTH-1:0] dest_data,
    output logic             dest_req,
    input  logic             dest_ack,
    output logic             xfer_done,
    output logic [15:0]      xfer_count,
    output logic             timeout_err
);

    typedef enum logic [1:0] {StIdle, StReq, StRel} state_e;

    localparam int unsigned CntW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT);

    state_e            state_q, state_d;
    logic [DEST_SYNC_FF-1:0] ack_sync_q, ack_sync_d;
    logic              ack_s;
    logic [WIDTH-1:0]  data_q, data_d;
    logic              req_q, req_d;
    logic              done_q, done_d;
    logic [15:0]       count_q, count_d;
    logic [CntW-1:0]   phase_cnt_q, phase_cnt_d;
    logic              tmo_q, tmo_d;
    logic              phase_hold;

    assign ack_s = ack_sync_q[DEST_SYNC_FF-1];

    always_comb begin
        ack_sync_d  = {ack_sync_q[DEST_SYNC_FF-2:0], dest_ack};
        state_d     = state_q;
        data_d      = data_q;
        req_d       = req_q;
        done_d      = 1'b0;
        count_d     = count_q;
        phase_cnt_d = phase_cnt_q;
        tmo_d       = tmo_q;
        phase_hold  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (s_valid && s_ready) begin
                    state_d     = StReq;
                    data_d      = s_data;
                    req_d       = 1'b1;
                    phase_cnt_d = '0;
                end
            end
            StReq: begin
                if (ack_s) begin
                    state_d     = StRel;
                    req_d       = 1'b0;
                    phase_cnt_d = '0;
                end else begin
                    phase_hold = 1'b1;
                end
            end
            StRel: begin
                if (!ack_s) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                    count_d = count_q + 16'd1;
                end else begin
                    phase_hold = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        // Counter saturates at TIMEOUT; the error flag only records, never aborts.
        if (phase_hold && (phase_cnt_q != CntMax)) begin
            phase_cnt_d = phase_cnt_q + 1'b1;
            if ((TIMEOUT > 0) && (phase_cnt_d == CntMax)) begin
                tmo_d = 1'b1;
            end
        end
    end

    always_ff @(posedge src_clk or negedge src_rst_n) begin
        if (!src_rst_n) begin
            state_q     <= StIdle;
            ack_sync_q  <= '0;
            data_q      <= '0;
            req_q       <= 1'b0;
            done_q      <= 1'b0;
            count_q     <= '0;
            phase_cnt_q <= '0;
            tmo_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            ack_sync_q  <= ack_sync_d;
            data_q      <= data_d;
            req_q       <= req_d;
            done_q      <= done_d;
            count_q     <= count_d;
            phase_cnt_q <= phase_cnt_d;
            tmo_q       <= tmo_d;
        end
    end

    assign s_ready     = (state_q == StIdle) && !ack_s;
    assign dest_data   = data_q;
    assign dest_req    = req_q;
    assign xfer_done   = done_q;
    assign xfer_count  = count_q;
    assign timeout_err = tmo_q;

endmodule

// File: tb/tb_cdc_handshake_src.sv
// Directed bench for cdc_handshake_src: table of transfers, latency/reset/timeout sequences,
// and a randomized-delay run, with a negedge monitor on stability and pulse shape.
module tb_cdc_handshake_src;

    localparam int unsigned W    = 32;
    localparam int unsigned NS   = 3;
    localparam int unsigned TMO  = 16;

    logic          src_clk = 1'b0;
    logic          src_rst_n = 1'b0;
    logic [W-1:0]  s_data = '0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [W-1:0]  dest_data;
    logic          dest_req;
    logic          dest_ack = 1'b0;
    logic          xfer_done;
    logic [15:0]   xfer_count;
    logic          timeout_err;

    int errors = 0;
    int checks = 0;
    int exp_count = 0;
    int exp_done = 0;
    int done_cnt = 0;

    typedef struct {
        logic [31:0] data;
        int          ack_dly;
        int          rel_dly;
        int          gap;
    } vec_t;

    vec_t vecs[8];

    cdc_handshake_src #(
        .WIDTH       (W),
        .DEST_SYNC_FF(NS),
        .TIMEOUT     (TMO)
    ) dut (
        .src_clk    (src_clk),
        .src_rst_n  (src_rst_n),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .dest_data  (dest_data),
        .dest_req   (dest_req),
        .dest_ack   (dest_ack),
        .xfer_done  (xfer_done),
        .xfer_count (xfer_count),
        .timeout_err(timeout_err)
    );

    always #5 src_clk = ~src_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: data only moves on a req rising edge; no ready while req; done is one cycle.
    logic         prev_req = 1'b0;
    logic         prev_done = 1'b0;
    logic         prev_rst = 1'b0;
    logic [W-1:0] prev_data = '0;

    always @(negedge src_clk) begin
        if (xfer_done) done_cnt++;
        if (src_rst_n && prev_rst) begin
            if (dest_req) chk("ready_low_in_req", 32'(s_ready), 32'd0);
            if (!(dest_req && !prev_req)) chk("data_stable", dest_data, prev_data);
            if (xfer_done) chk("done_one_cycle", 32'(prev_done), 32'd0);
        end
        prev_req  <= dest_req;
        prev_done <= xfer_done;
        prev_rst  <= src_rst_n;
        prev_data <= dest_data;
    end

    task automatic do_xfer(input logic [31:0] data, input int ack_dly, input int rel_dly,
                           input int gap);
        int n;
        repeat (gap) @(negedge src_clk);
        s_data  = data;
        s_valid = 1'b1;
        n = 0;
        while (!s_ready && n < 200) begin
            @(negedge src_clk);
            n++;
        end
        chk("accept_ready", 32'(s_ready), 32'd1);
        @(negedge src_clk);
        s_valid = 1'b0;
        s_data  = ~data;
        chk("req_rise", 32'(dest_req), 32'd1);
        chk("data_latched", dest_data, data);
        repeat (ack_dly) @(negedge src_clk);
        dest_ack = 1'b1;
        n = 0;
        while (dest_req && n < 200) begin
            @(negedge src_clk);
            n++;
        end
        chk("req_fall", 32'(dest_req), 32'd0);
        chk("data_hold_rel", dest_data, data);
        repeat (rel_dly) @(negedge src_clk);
        dest_ack = 1'b0;
        n = 0;
        while (!xfer_done && n < 200) begin
            @(negedge src_clk);
            n++;
        end
        exp_count = (exp_count + 1) % 65536;
        exp_done++;
        chk("xfer_done", 32'(xfer_done), 32'd1);
        chk("xfer_count", 32'(xfer_count), 32'(exp_count));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{32'hDEADBEEF, 5, 5, 0};
        vecs[1] = '{32'h00000000, 0, 0, 0};
        vecs[2] = '{32'hFFFFFFFF, 8, 8, 0};
        vecs[3] = '{32'h12345678, 1, 3, 2};
        vecs[4] = '{32'hA5A5A5A5, 0, 7, 0};
        vecs[5] = '{32'h5A5A5A5A, 6, 0, 1};
        vecs[6] = '{32'h80000001, 2, 2, 0};
        vecs[7] = '{32'hCAFEF00D, 4, 1, 3};

        // Reset values
        #1;
        chk("rst_req", 32'(dest_req), 32'd0);
        chk("rst_data", dest_data, 32'd0);
        chk("rst_done", 32'(xfer_done), 32'd0);
        chk("rst_count", 32'(xfer_count), 32'd0);
        chk("rst_tmo", 32'(timeout_err), 32'd0);
        chk("rst_ready", 32'(s_ready), 32'd1);
        repeat (2) @(negedge src_clk);
        #2 src_rst_n = 1'b1;
        @(negedge src_clk);

        for (int i = 0; i < 8; i++) begin
            do_xfer(vecs[i].data, vecs[i].ack_dly, vecs[i].rel_dly, vecs[i].gap);
        end
        chk("no_timeout_short", 32'(timeout_err), 32'd0);

        // Sync latency: NS sync edges, then the FSM edge. s_valid held high mid-transfer.
        @(negedge src_clk);
        chk("lat_ready", 32'(s_ready), 32'd1);
        s_data  = 32'h0000AAAA;
        s_valid = 1'b1;
        @(negedge src_clk);
        chk("lat_req", 32'(dest_req), 32'd1);
        s_data   = 32'h0000BBBB;
        dest_ack = 1'b1;
        repeat (NS) @(posedge src_clk);
        #1 chk("lat_req_before_sync", 32'(dest_req), 32'd1);
        @(posedge src_clk);
        #1 chk("lat_req_fall", 32'(dest_req), 32'd0);
        chk("lat_data_hold", dest_data, 32'h0000AAAA);
        @(negedge src_clk);
        s_valid  = 1'b0;
        dest_ack = 1'b0;
        repeat (NS) @(posedge src_clk);
        #1 chk("lat_done_before_sync", 32'(xfer_done), 32'd0);
        @(posedge src_clk);
        #1 chk("lat_done", 32'(xfer_done), 32'd1);
        exp_count++;
        exp_done++;
        chk("lat_count", 32'(xfer_count), 32'(exp_count));
        chk("lat_data_final", dest_data, 32'h0000AAAA);

        // Reset mid-transfer with ack held high (stale ack afterwards)
        @(negedge src_clk);
        s_data  = 32'h11112222;
        s_valid = 1'b1;
        @(negedge src_clk);
        s_valid  = 1'b0;
        chk("mid_req", 32'(dest_req), 32'd1);
        dest_ack = 1'b1;
        @(negedge src_clk);
        #2 src_rst_n = 1'b0;
        #1 chk("mid_rst_req", 32'(dest_req), 32'd0);
        chk("mid_rst_count", 32'(xfer_count), 32'd0);
        chk("mid_rst_data", dest_data, 32'd0);
        exp_count = 0;
        @(negedge src_clk);
        #2 src_rst_n = 1'b1;
        repeat (5) @(negedge src_clk);
        chk("stale_ready", 32'(s_ready), 32'd0);
        s_data  = 32'h33334444;
        s_valid = 1'b1;
        repeat (4) @(negedge src_clk);
        chk("stale_no_accept", 32'(dest_req), 32'd0);
        s_valid = 1'b0;
        @(negedge src_clk);
        dest_ack = 1'b0;
        repeat (NS - 1) @(posedge src_clk);
        #1 chk("stale_ready_early", 32'(s_ready), 32'd0);
        @(posedge src_clk);
        #1 chk("stale_ready_back", 32'(s_ready), 32'd1);
        chk("stale_no_done", 32'(done_cnt), 32'(exp_done));
        chk("stale_count", 32'(xfer_count), 32'd0);

        // Timeout: never ack for TMO cycles of REQ, then complete normally
        @(negedge src_clk);
        chk("tmo_clear", 32'(timeout_err), 32'd0);
        s_data  = 32'h7777EEEE;
        s_valid = 1'b1;
        @(posedge src_clk);
        #1 s_valid = 1'b0;
        repeat (TMO - 1) @(posedge src_clk);
        #1 chk("tmo_not_yet", 32'(timeout_err), 32'd0);
        @(posedge src_clk);
        #1 chk("tmo_set", 32'(timeout_err), 32'd1);
        chk("tmo_still_req", 32'(dest_req), 32'd1);
        @(negedge src_clk);
        dest_ack = 1'b1;
        repeat (NS + 1) @(posedge src_clk);
        #1 chk("tmo_req_fall", 32'(dest_req), 32'd0);
        @(negedge src_clk);
        dest_ack = 1'b0;
        repeat (NS + 1) @(posedge src_clk);
        #1 chk("tmo_done", 32'(xfer_done), 32'd1);
        exp_count++;
        exp_done++;
        chk("tmo_count", 32'(xfer_count), 32'(exp_count));
        chk("tmo_sticky", 32'(timeout_err), 32'd1);
        chk("tmo_data", dest_data, 32'h7777EEEE);

        // Random ack/release delays and valid gaps
        @(negedge src_clk);
        for (int i = 0; i < 150; i++) begin
            do_xfer($urandom, $urandom_range(0, 20), $urandom_range(0, 20), $urandom_range(0, 3));
        end
        chk("rand_tmo_sticky", 32'(timeout_err), 32'd1);

        repeat (5) @(posedge src_clk);
        #1 chk("done_total", 32'(done_cnt), 32'(exp_done));
        chk("count_total", 32'(xfer_count), 32'(exp_count));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
